// File: rtl/dm163_pkg.sv
// dm163_pkg: shared DM163 link constants and bank encoding
package dm163_pkg;
    localparam int N_CH       = 24;
    localparam int PWM_W      = 8;
    localparam int GAMMA_W    = 6;
    localparam int GAMMA_BITS = N_CH * GAMMA_W;
    localparam int PWM_BITS   = N_CH * PWM_W;
    typedef enum logic {
        BANK_GAMMA = 1'b0,
        BANK_PWM   = 1'b1
    } dm163_bank_e;
endpackage

// File: rtl/dm163_rx_sync.sv
// dm163_rx_sync: 2-flop synchronizer with a third flop for rising-edge detect
module dm163_rx_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);
    logic [W-1:0] s1, s2, s3;
    // metastability chain plus delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign q    = s2;
    assign rise = s2 & ~s3;
endmodule

// File: rtl/dm163_receiver.sv
// dm163_receiver: DM163 link decoder into gamma/PWM banks with a one-entry row buffer (option: DM163_RX_LEN_CHECK_EN)
module dm163_receiver
    import dm163_pkg::*;
#(
    parameter int N_CH    = dm163_pkg::N_CH,
    parameter int PWM_W   = dm163_pkg::PWM_W,
    parameter int GAMMA_W = dm163_pkg::GAMMA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_sda,
    input  logic               s_clk,
    input  logic               s_rst,
    input  logic               lat,
    input  logic               sb,
    input  logic [7:0]         channel,
    output logic               frame_valid,
    input  logic               frame_ack,
    output logic               frame_sb,
    output logic [2:0]         frame_row,
    output logic               row_err,
    input  logic [4:0]         rd_ch,
    output logic [PWM_W-1:0]   rd_pwm,
    output logic [GAMMA_W-1:0] rd_gamma,
    output logic [7:0]         bit_count,
    output logic               overflow,
    output logic               len_err
);
    localparam int SH_W = N_CH * PWM_W;

    logic sda_q, sda_rise, sclk_q, sclk_rise, srst_q, srst_rise;
    logic lat_q, lat_rise, sb_q, sb_rise;
    logic [7:0] ch_q, ch_rise;
    logic [SH_W-1:0] shreg;
    logic [PWM_W-1:0] pwm_bank [N_CH];
    logic [GAMMA_W-1:0] gamma_bank [N_CH];
    logic [2:0] row_idx;
    logic [3:0] ones;
    logic do_shift, do_latch, pop;
    dm163_bank_e bank_sel;
    logic unused_sync;

    dm163_rx_sync #(.W(1)) u_sda  (.clk(clk), .rst(rst), .d(s_sda),   .q(sda_q),  .rise(sda_rise));
    dm163_rx_sync #(.W(1)) u_sclk (.clk(clk), .rst(rst), .d(s_clk),   .q(sclk_q), .rise(sclk_rise));
    dm163_rx_sync #(.W(1)) u_srst (.clk(clk), .rst(rst), .d(s_rst),   .q(srst_q), .rise(srst_rise));
    dm163_rx_sync #(.W(1)) u_lat  (.clk(clk), .rst(rst), .d(lat),     .q(lat_q),  .rise(lat_rise));
    dm163_rx_sync #(.W(1)) u_sb   (.clk(clk), .rst(rst), .d(sb),      .q(sb_q),   .rise(sb_rise));
    dm163_rx_sync #(.W(8)) u_ch   (.clk(clk), .rst(rst), .d(channel), .q(ch_q),   .rise(ch_rise));

    assign unused_sync = ^{sda_rise, sclk_q, srst_rise, lat_q, sb_rise, ch_rise};

    // chip reset (s_rst low) masks every link edge
    assign do_shift = sclk_rise & srst_q;
    assign do_latch = lat_rise & srst_q;
    assign pop      = frame_valid & frame_ack;
    assign bank_sel = dm163_bank_e'(sb_q);

    // row index of the set bit and one-hot qualification of channel
    always_comb begin
        row_idx = '0;
        ones    = '0;
        for (int i = 0; i < 8; i++) begin
            if (ch_q[i]) row_idx = 3'(i);
            ones = ones + {3'b0, ch_q[i]};
        end
    end

    // shift register, bit counter and the one-entry row buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg       <= '0;
            bit_count   <= '0;
            frame_valid <= 1'b0;
            frame_sb    <= 1'b0;
            frame_row   <= '0;
            row_err     <= 1'b0;
            overflow    <= 1'b0;
        end else if (!srst_q) begin
            shreg       <= '0;
            bit_count   <= '0;
            frame_valid <= 1'b0;
        end else begin
            if (do_shift) shreg <= {shreg[SH_W-2:0], sda_q};
            if (do_latch) bit_count <= '0;
            else if (do_shift && bit_count != 8'hFF) bit_count <= bit_count + 8'd1;
            if (do_latch) begin
                if (!frame_valid || pop) begin
                    frame_valid <= 1'b1;
                    frame_sb    <= sb_q;
                    frame_row   <= row_idx;
                    row_err     <= ones != 4'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (pop) begin
                frame_valid <= 1'b0;
            end
        end
    end

    // bank load at latch: the selected bank takes its slice of every channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                pwm_bank[c]   <= '0;
                gamma_bank[c] <= '0;
            end
        end else if (do_latch) begin
            for (int c = 0; c < N_CH; c++) begin
                if (bank_sel == BANK_PWM) pwm_bank[c] <= shreg[c*PWM_W +: PWM_W];
                else gamma_bank[c] <= shreg[c*GAMMA_W +: GAMMA_W];
            end
        end
    end

    // registered bank read; out-of-range addresses read zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pwm   <= '0;
            rd_gamma <= '0;
        end else begin
            rd_pwm   <= rd_ch < 5'(N_CH) ? pwm_bank[rd_ch] : '0;
            rd_gamma <= rd_ch < 5'(N_CH) ? gamma_bank[rd_ch] : '0;
        end
    end

`ifdef DM163_RX_LEN_CHECK_EN
    // sticky flag when the latched bit count does not fit the selected bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) len_err <= 1'b0;
        else if (do_latch && bit_count != (bank_sel == BANK_PWM ? 8'(PWM_BITS) : 8'(GAMMA_BITS)))
            len_err <= 1'b1;
    end
`else
    assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_dm163_receiver.sv
// tb_dm163_receiver: randomized link frames checked against a bit-history reference model
module tb_dm163_receiver;
    logic clk = 1'b0, rst = 1'b1;
    logic s_sda = 1'b0, s_clk = 1'b0, s_rst = 1'b1, lat = 1'b0, sb = 1'b0, frame_ack = 1'b0;
    logic [7:0] channel = 8'h01;
    logic [4:0] rd_ch = '0;
    logic frame_valid, frame_sb, row_err, overflow, len_err;
    logic [2:0] frame_row;
    logic [7:0] rd_pwm, bit_count;
    logic [5:0] rd_gamma;

    dm163_receiver dut (
        .clk(clk), .rst(rst), .s_sda(s_sda), .s_clk(s_clk), .s_rst(s_rst), .lat(lat), .sb(sb),
        .channel(channel), .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_sb(frame_sb),
        .frame_row(frame_row), .row_err(row_err), .rd_ch(rd_ch), .rd_pwm(rd_pwm),
        .rd_gamma(rd_gamma), .bit_count(bit_count), .overflow(overflow), .len_err(len_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit hist[$];
    int m_cnt = 0;
    logic [7:0] m_pwm [24];
    logic [5:0] m_gam [24];
    bit m_valid = 0, m_sb = 0, m_err = 0, m_ovf = 0, m_len = 0;
    logic [2:0] m_row = '0;
    bit exp_len_150;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit age(input int k);
        return k < hist.size() ? hist[hist.size()-1-k] : 1'b0;
    endfunction

    task automatic send_bit(input bit b);
        @(negedge clk) s_sda = b;
        repeat (3) @(negedge clk);
        s_clk = 1'b1;
        repeat (3) @(negedge clk);
        s_clk = 1'b0;
        hist.push_back(b);
        if (hist.size() > 192) void'(hist.pop_front());
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic send_vec(input logic [191:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    function automatic logic [191:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_latch(input bit sbv, input logic [7:0] ch, input bit with_ack);
        @(negedge clk) begin sb = sbv; channel = ch; end
        repeat (3) @(negedge clk);
        lat = 1'b1;
        repeat (2) @(negedge clk);
        if (with_ack) frame_ack = 1'b1;
        @(negedge clk) begin frame_ack = 1'b0; lat = 1'b0; end
        repeat (6) @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            if (sbv) for (int b = 0; b < 8; b++) m_pwm[c][b] = age(8 * c + b);
            else for (int b = 0; b < 6; b++) m_gam[c][b] = age(6 * c + b);
        end
`ifdef DM163_RX_LEN_CHECK_EN
        if (m_cnt != (sbv ? 192 : 144)) m_len = 1'b1;
`endif
        m_cnt = 0;
        if (!m_valid || with_ack) begin
            m_valid = 1'b1;
            m_sb = sbv;
            m_err = $countones(ch) != 1;
            for (int i = 0; i < 8; i++) if (ch[i]) m_row = 3'(i);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, frame_valid, m_valid);
        check({tag, ".ovf"}, overflow, m_ovf);
        check({tag, ".len"}, len_err, m_len);
        check({tag, ".cnt"}, bit_count, m_cnt);
        if (m_valid) begin
            check({tag, ".sb"}, frame_sb, m_sb);
            check({tag, ".rerr"}, row_err, m_err);
            if (!m_err) check({tag, ".row"}, frame_row, m_row);
        end
    endtask

    task automatic read_ch(input int c, output logic [7:0] p, output logic [5:0] g);
        @(negedge clk) rd_ch = 5'(c);
        @(negedge clk) begin p = rd_pwm; g = rd_gamma; end
    endtask

    task automatic check_banks(input string tag);
        logic [7:0] p;
        logic [5:0] g;
        for (int c = 0; c < 24; c++) begin
            read_ch(c, p, g);
            check($sformatf("%s.pwm%0d", tag, c), p, m_pwm[c]);
            check($sformatf("%s.gam%0d", tag, c), g, m_gam[c]);
        end
    endtask

    task automatic ack_row(input string tag);
        @(negedge clk) frame_ack = 1'b1;
        @(negedge clk) frame_ack = 1'b0;
        m_valid = 1'b0;
        check({tag, ".popped"}, frame_valid, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, frame_valid, 0);
        check({tag, ".sb"}, frame_sb, 0);
        check({tag, ".row"}, frame_row, 0);
        check({tag, ".rerr"}, row_err, 0);
        check({tag, ".pwm"}, rd_pwm, 0);
        check({tag, ".gam"}, rd_gamma, 0);
        check({tag, ".cnt"}, bit_count, 0);
        check({tag, ".ovf"}, overflow, 0);
        check({tag, ".len"}, len_err, 0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 24; c++) begin
            m_pwm[c] = '0;
            m_gam[c] = '0;
        end
        hist.delete();
        m_cnt = 0;
        m_valid = 0;
        m_ovf = 0;
        m_len = 0;
    endtask

    initial begin
        logic [143:0] gv;
        logic [191:0] pv;
        logic [7:0] p;
        logic [5:0] g;
        model_reset();
`ifdef DM163_RX_LEN_CHECK_EN
        exp_len_150 = 1'b1;
`else
        exp_len_150 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        gv = {8{6'd14, 6'd63, 6'd59}};
        send_vec({48'b0, gv}, 144);
        @(negedge clk) check("gamma.precnt", bit_count, 144);
        do_latch(1'b0, 8'h01, 1'b0);
        check_state("gamma");
        read_ch(0, p, g);  check("gamma.ch0", g, 59);
        read_ch(1, p, g);  check("gamma.ch1", g, 63);
        read_ch(2, p, g);  check("gamma.ch2", g, 14);
        read_ch(23, p, g); check("gamma.ch23", g, 14);
        check_banks("gamma");
        ack_row("gamma");

        for (int c = 0; c < 24; c++) pv[8*c +: 8] = 8'(c + 1);
        send_vec(pv, 192);
        do_latch(1'b1, 8'h20, 1'b0);
        check_state("pwm");
        check("pwm.row5", frame_row, 5);
        check("pwm.rerr", row_err, 0);
        read_ch(5, p, g);  check("pwm.ch5", p, 6);
        read_ch(25, p, g); check("pwm.oob_p", p, 0); check("pwm.oob_g", g, 0);
        check_banks("pwm");

        send_vec(rand_vec(), 192);
        do_latch(1'b1, 8'h02, 1'b1);
        check_state("simack");
        check("simack.ovf", overflow, 0);
        check("simack.row", frame_row, 1);

        send_vec(rand_vec(), 192);
        do_latch(1'b1, 8'h40, 1'b0);
        check_state("ovf");
        check("ovf.set", overflow, 1);
        check("ovf.keeprow", frame_row, 1);
        check_banks("ovf");
        ack_row("ovf");

        send_vec(rand_vec(), 150);
        do_latch(1'b0, 8'h03, 1'b0);
        check_state("len");
        check("len.flag", len_err, exp_len_150);
        check("len.rowerr", row_err, 1);
        check_banks("len");
        ack_row("len");

        send_vec(rand_vec(), 100);
        @(negedge clk) s_rst = 1'b0;
        repeat (5) @(negedge clk);
        hist.delete();
        m_cnt = 0;
        m_valid = 0;
        check("srst.cnt", bit_count, 0);
        check("srst.valid", frame_valid, 0);
        s_rst = 1'b1;
        repeat (5) @(negedge clk);
        send_vec(rand_vec(), 192);
        do_latch(1'b1, 8'h80, 1'b0);
        check_state("srst");
        check("srst.cnt0", bit_count, 0);
        check_banks("srst");
        ack_row("srst");

        send_vec(rand_vec(), 50);
        @(negedge clk) rst = 1'b1;
        #1;
        model_reset();
        check_zero("arst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_banks("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm163_receiver.md
# dm163_receiver

Cycle-accurate receiving end of the DM163 serial LED-driver link. Oversamples the `s_sda`/`s_clk`/`lat`/`sb`/`s_rst` lines and the 8-bit row-select `channel` driven by the colorshield driver. Decodes them into a 24-channel gamma bank and a 24-channel PWM bank, and reports every latched row to a consumer through a one-entry valid/ack buffer. It serves as the on-chip loopback monitor and as the behavioural DM163 model for system benches.

## Interface
Parameters:
- `N_CH`, 24 — LED channels per driver.
- `PWM_W`, 8 — PWM bits per channel (bank 1, `sb`=1).
- `GAMMA_W`, 6 — gamma bits per channel (bank 0, `sb`=0).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; every register in the block is clocked by it.
- `rst`  in  1  asynchronous, active-high reset.
- `s_sda`, `s_clk`, `s_rst`, `lat`, `sb`  in  1 each  DM163 link lines. These are asynchronous to `clk`. `s_rst` is active-low.
- `channel`  in  8  one-hot row select.
- `frame_valid`  out  1  a latched row is pending.
- `frame_ack`  in  1  consumer pops the pending row.
- `frame_sb`  out  1  bank of the pending row (0 = gamma, 1 = PWM).
- `frame_row`  out  3  index of the single set bit of `channel`, captured at latch.
- `row_err`  out  1  `channel` was not one-hot at latch; qualifies the pending row.
- `rd_ch`  in  5  bank read address.
- `rd_pwm`  out  8  PWM value of `rd_ch`, registered.
- `rd_gamma`  out  6  gamma value of `rd_ch`, registered.
- `bit_count`  out  8  bits shifted since the last latch; saturates at 255.
- `overflow`  out  1  sticky: a latch arrived while `frame_valid` was set.
- `len_err`  out  1  sticky: the latch length did not match the bank.

## Operation
Input conditioning:
- All five link lines and `channel` pass through 2-flop synchronizers.
- Rising edges of the synchronized `s_clk` and `lat` are detected against a third flop.

Shift path:
- On each `s_clk` rising edge, `shreg[191:0] <= {shreg[190:0], s_sda}`, i.e. MSB-first. After 192 bits, `shreg[8c+7:8c]` holds channel c. After 144 bits, `shreg[6c+5:6c]` holds channel c.
- `bit_count` increments per edge and saturates at 255.

Latch (`lat` rising edge), all in one cycle:
- If `sb`=1, PWM bank[c] ← `shreg[8c+7:8c]`. If `sb`=0, gamma bank[c] ← `shreg[6c+5:6c]`.
- `bit_count` ← 0; `shreg` is retained.
- If `frame_valid`=0, load `frame_sb`, `frame_row`, `row_err` and set `frame_valid`.
- If `frame_valid`=1, set `overflow`. The pending row is not overwritten. The banks still update.

Handshake:
- `frame_valid` clears on the cycle after `frame_ack`=1 is sampled while it is set.
- A simultaneous ack and latch pops the old row and loads the new one. `frame_valid` stays 1 and `overflow` is not set.

Chip reset (`s_rst` synchronized low):
- Clears `shreg`, `bit_count` and `frame_valid`. The banks and sticky flags keep their values.
- Edges on `s_clk` and `lat` are ignored while `s_rst` is low.
- The chip reset takes priority over a latch in the same cycle.

`rst`:
- Clears every register. Both banks = 0. All outputs = 0, including `rd_pwm`/`rd_gamma` and the sticky flags.

`rd_ch` ≥ 24 reads 0.

## Timing
- Link-line change → synchronized: 2 `clk`. Edge detected: cycle 3.
- Shift/latch register update: end of cycle 3.
- `frame_valid` visible: 4 `clk` after the `lat` rising edge reaches the pin.
- Bank read: `rd_pwm`/`rd_gamma` valid 1 cycle after `rd_ch`. A read of a channel being latched in the same cycle returns the new value one cycle later.
- Link requirement: `s_clk`/`lat` high and low phases ≥ 2 `clk`. `s_sda`, `sb` and `channel` stable ≥ 3 `clk` before the qualifying edge.

## Configuration
- `DM163_RX_LEN_CHECK_EN` defined: at each latch, compare `bit_count` against 144 (`sb`=0) or 192 (`sb`=1). A mismatch sets sticky `len_err`.
- Not defined: `len_err` is tied to 0 and the comparator is not built. `bit_count` is still present.

## Structure
- `dm163_pkg` holds:
  - `N_CH`, `PWM_W`, `GAMMA_W`;
  - `GAMMA_BITS`=144 and `PWM_BITS`=192;
  - a `dm163_bank_e` enum (`BANK_GAMMA`, `BANK_PWM`).
- Sub-module `dm163_rx_sync`: 2-flop synchronizer plus rising-edge detector, one instance per line. `channel` uses a bus-width instance.

## Test plan
- Reset then gamma frame: 144 bits of `{8{6'd14,6'd63,6'd59}}` with `sb`=0, then `lat` → gamma ch0=59, ch1=63, ch2=14, ch23=14; `frame_sb`=0; `len_err`=0.
- PWM frame: 192 bits with ch c = c+1 (MSB-first), `sb`=1, `channel`=8'h20, `lat` → `rd_pwm`(ch 5)=6; `frame_row`=5; `row_err`=0.
- Two latches with no ack → second latch sets `overflow`; the pending row still holds the first `frame_row`. A simultaneous ack and latch → no `overflow`.
- 150 bits with `sb`=0 then `lat` → `len_err`=1 (with `DM163_RX_LEN_CHECK_EN`), 0 without it. `channel`=8'h03 → `row_err`=1.
- `s_rst` low mid-frame after 100 bits, then high, then a full 192-bit frame → the banks hold the last full frame only; `bit_count`=0 after `lat`.
- `rst` pulse mid-shift → all outputs 0 within the same cycle (asynchronous); reads of all 24 channels return 0.
